// File: rtl/alloc_arbiter.sv
// alloc_arbiter: round-robin arbiter/sequencer placing two clients in front of the linked-memory allocator.
// Optional feature macro ALLOC_ARB_PAIR_EN: accept an alloc and a free from opposite clients in one cycle.
module alloc_arbiter #(
  parameter int DATA_SZ = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_req0_valid,
  output logic               o_req0_ready,
  input  logic [1:0]         i_req0_op,
  input  logic [DATA_SZ-1:0] i_req0_addr,
  input  logic [DATA_SZ-1:0] i_req0_data,
  input  logic               i_req1_valid,
  output logic               o_req1_ready,
  input  logic [1:0]         i_req1_op,
  input  logic [DATA_SZ-1:0] i_req1_addr,
  input  logic [DATA_SZ-1:0] i_req1_data,
  output logic               o_rsp0_valid,
  output logic [DATA_SZ-1:0] o_rsp0_data,
  output logic               o_rsp1_valid,
  output logic [DATA_SZ-1:0] o_rsp1_data,
  output logic               o_alloc,
  output logic [DATA_SZ-1:0] o_data,
  output logic               o_free,
  output logic [DATA_SZ-1:0] o_faddr,
  output logic               o_wr,
  output logic [DATA_SZ-1:0] o_waddr,
  output logic [DATA_SZ-1:0] o_wdata,
  output logic               o_rd,
  output logic [DATA_SZ-1:0] o_raddr,
  input  logic [DATA_SZ-1:0] i_oaddr,
  input  logic [DATA_SZ-1:0] i_rdata,
  input  logic               i_err,
  output logic               o_halt
);

  typedef enum logic [1:0] {
    OP_ALLOC = 2'b00,
    OP_FREE  = 2'b01,
    OP_READ  = 2'b10,
    OP_WRITE = 2'b11
  } op_e;

  logic [1:0]         reqValid;
  op_e                reqOp   [2];
  logic [DATA_SZ-1:0] reqAddr [2];
  logic [DATA_SZ-1:0] reqData [2];

  logic               halt_q, halt_d;
  logic               lastGnt_q, lastGnt_d;
  logic [1:0]         tagValid_q, tagValid_d;
  op_e                tagOp_q [2];
  op_e                tagOp_d [2];

  logic               blocked;
  logic               pairHit;
  logic [1:0]         gnt;
  logic [1:0]         rspValid;
  logic [DATA_SZ-1:0] rspData [2];

  assign reqValid   = {i_req1_valid, i_req0_valid};
  assign reqOp[0]   = op_e'(i_req0_op);
  assign reqOp[1]   = op_e'(i_req1_op);
  assign reqAddr[0] = i_req0_addr;
  assign reqAddr[1] = i_req1_addr;
  assign reqData[0] = i_req0_data;
  assign reqData[1] = i_req1_data;

  // An error strobe belongs to the previous op, so nothing new may start in that cycle either.
  assign blocked = i_rst | i_err | halt_q;

`ifdef ALLOC_ARB_PAIR_EN
  assign pairHit = reqValid[0] && reqValid[1] &&
                   (((reqOp[0] == OP_ALLOC) && (reqOp[1] == OP_FREE)) ||
                    ((reqOp[0] == OP_FREE)  && (reqOp[1] == OP_ALLOC)));
`else
  assign pairHit = 1'b0;
`endif

  // lastGnt_q holds the id of the most recent single winner; the other id wins a tie.
  always_comb begin
    gnt = 2'b00;
    if (!blocked) begin
      if (pairHit) begin
        gnt = 2'b11;
      end else if (reqValid[0] && reqValid[1]) begin
        gnt = lastGnt_q ? 2'b01 : 2'b10;
      end else begin
        gnt = reqValid;
      end
    end
  end

  assign o_req0_ready = gnt[0];
  assign o_req1_ready = gnt[1];

  always_comb begin
    o_alloc = 1'b0;
    o_data  = '0;
    o_free  = 1'b0;
    o_faddr = '0;
    o_wr    = 1'b0;
    o_waddr = '0;
    o_wdata = '0;
    o_rd    = 1'b0;
    o_raddr = '0;
    for (int r = 0; r < 2; r++) begin
      if (gnt[r]) begin
        case (reqOp[r])
          OP_ALLOC: begin
            o_alloc = 1'b1;
            o_data  = reqData[r];
          end
          OP_FREE: begin
            o_free  = 1'b1;
            o_faddr = reqAddr[r];
          end
          OP_READ: begin
            o_rd    = 1'b1;
            o_raddr = reqAddr[r];
          end
          OP_WRITE: begin
            o_wr    = 1'b1;
            o_waddr = reqAddr[r];
            o_wdata = reqData[r];
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    halt_d     = halt_q | i_err;
    lastGnt_d  = lastGnt_q;
    if (gnt == 2'b01) lastGnt_d = 1'b0;
    if (gnt == 2'b10) lastGnt_d = 1'b1;
    tagValid_d = gnt;
    tagOp_d[0] = reqOp[0];
    tagOp_d[1] = reqOp[1];
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      halt_q     <= 1'b0;
      lastGnt_q  <= 1'b1;
      tagValid_q <= 2'b00;
      tagOp_q[0] <= OP_ALLOC;
      tagOp_q[1] <= OP_ALLOC;
    end else begin
      halt_q     <= halt_d;
      lastGnt_q  <= lastGnt_d;
      tagValid_q <= tagValid_d;
      tagOp_q[0] <= tagOp_d[0];
      tagOp_q[1] <= tagOp_d[1];
    end
  end

  // Results are routed by the tag captured at accept time; data is zero whenever no strobe.
  always_comb begin
    rspValid   = 2'b00;
    rspData[0] = '0;
    rspData[1] = '0;
    for (int r = 0; r < 2; r++) begin
      rspValid[r] = tagValid_q[r] & ~i_err;
      if (rspValid[r]) begin
        case (tagOp_q[r])
          OP_ALLOC: rspData[r] = i_oaddr;
          OP_READ:  rspData[r] = i_rdata;
          default:  rspData[r] = '0;
        endcase
      end
    end
  end

  assign o_rsp0_valid = rspValid[0];
  assign o_rsp1_valid = rspValid[1];
  assign o_rsp0_data  = rspData[0];
  assign o_rsp1_data  = rspData[1];
  assign o_halt       = halt_q;

endmodule

// File: tb/tb_alloc_arbiter.sv
// Self-checking bench for alloc_arbiter with a small allocator model; honours ALLOC_ARB_PAIR_EN.
module tb_alloc_arbiter;

  localparam int DW = 16;
  localparam logic [1:0] OpAlloc = 2'b00;
  localparam logic [1:0] OpFree  = 2'b01;
  localparam logic [1:0] OpRead  = 2'b10;
  localparam logic [1:0] OpWrite = 2'b11;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_req0_valid, i_req1_valid;
  logic          o_req0_ready, o_req1_ready;
  logic [1:0]    i_req0_op, i_req1_op;
  logic [DW-1:0] i_req0_addr, i_req1_addr, i_req0_data, i_req1_data;
  logic          o_rsp0_valid, o_rsp1_valid;
  logic [DW-1:0] o_rsp0_data, o_rsp1_data;
  logic          o_alloc, o_free, o_wr, o_rd;
  logic [DW-1:0] o_data, o_faddr, o_waddr, o_wdata, o_raddr;
  logic [DW-1:0] i_oaddr, i_rdata;
  logic          i_err;
  logic          o_halt;

  alloc_arbiter #(.DATA_SZ(DW)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_req0_valid(i_req0_valid), .o_req0_ready(o_req0_ready), .i_req0_op(i_req0_op),
    .i_req0_addr(i_req0_addr), .i_req0_data(i_req0_data),
    .i_req1_valid(i_req1_valid), .o_req1_ready(o_req1_ready), .i_req1_op(i_req1_op),
    .i_req1_addr(i_req1_addr), .i_req1_data(i_req1_data),
    .o_rsp0_valid(o_rsp0_valid), .o_rsp0_data(o_rsp0_data),
    .o_rsp1_valid(o_rsp1_valid), .o_rsp1_data(o_rsp1_data),
    .o_alloc(o_alloc), .o_data(o_data), .o_free(o_free), .o_faddr(o_faddr),
    .o_wr(o_wr), .o_waddr(o_waddr), .o_wdata(o_wdata), .o_rd(o_rd), .o_raddr(o_raddr),
    .i_oaddr(i_oaddr), .i_rdata(i_rdata), .i_err(i_err), .o_halt(o_halt)
  );

  always #5 i_clk = ~i_clk;

  // Allocator stand-in: 256 cells from 0x5000, LIFO reuse of freed cells, error when empty.
  logic [DW-1:0] freeList [$];
  logic [DW-1:0] memModel [256];

  always @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      freeList.delete();
      for (int k = 0; k < 256; k++) freeList.push_back(16'h5000 + 16'(k));
      i_oaddr <= '0;
      i_rdata <= '0;
      i_err   <= 1'b0;
    end else begin
      i_err <= 1'b0;
      if (o_wr) memModel[o_waddr[7:0]] <= o_wdata;
      if (o_rd) i_rdata <= memModel[o_raddr[7:0]];
      if (o_alloc && o_free) begin
        i_oaddr <= o_faddr;
      end else begin
        if (o_free) freeList.push_front(o_faddr);
        if (o_alloc) begin
          if (freeList.size() == 0) i_err <= 1'b1;
          else i_oaddr <= freeList.pop_front();
        end
      end
    end
  end

  int testsRun = 0;
  int testsFailed = 0;

  task automatic checkOutput(input string name, input logic [DW-1:0] actual, input logic [DW-1:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkFlag(input string name, input logic actual, input logic expected);
    checkOutput(name, {15'b0, actual}, {15'b0, expected});
  endtask

  task automatic applyStimulus(input logic v0, input logic [1:0] op0, input logic [DW-1:0] a0,
                               input logic [DW-1:0] d0, input logic v1, input logic [1:0] op1,
                               input logic [DW-1:0] a1, input logic [DW-1:0] d1);
    i_req0_valid = v0; i_req0_op = op0; i_req0_addr = a0; i_req0_data = d0;
    i_req1_valid = v1; i_req1_op = op1; i_req1_addr = a1; i_req1_data = d1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, OpAlloc, 16'h0, 16'h0, 1'b0, OpAlloc, 16'h0, 16'h0);
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic doReset();
    i_rst = 1'b1;
    idle();
    step();
    step();
    i_rst = 1'b0;
  endtask

  task automatic newReq(output logic v, output logic [1:0] op, output logic [DW-1:0] a, output logic [DW-1:0] d);
    v  = ($urandom_range(0, 3) != 0);
    op = 2'($urandom_range(0, 3));
    a  = 16'h5000 + 16'($urandom_range(0, 255));
    d  = 16'($urandom);
  endtask

  typedef struct {
    logic v0; logic [1:0] op0; logic [DW-1:0] a0; logic [DW-1:0] d0;
    logic v1; logic [1:0] op1; logic [DW-1:0] a1; logic [DW-1:0] d1;
    logic r0; logic r1; logic rv0; logic rv1;
  } vec_t;

  typedef struct {
    int due;
    int id;
    logic [1:0] op;
  } exp_t;

  vec_t vecs [8];
  exp_t expQ [$];
  exp_t ent;
  logic rv0, rv1, sawRdy0, sawRdy1, e0, e1, pair, halted, x0, x1;
  logic [1:0] rop0, rop1;
  logic [DW-1:0] ra0, ra1, rd0, rd1, xd0, xd1, dat;
  int lastWinner;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    // Requests presented during reset must not leak through.
    i_rst = 1'b1;
    applyStimulus(1'b1, OpAlloc, 16'h0, 16'h1234, 1'b1, OpRead, 16'h5000, 16'h0);
    @(negedge i_clk);
    checkFlag("reset_halt", o_halt, 1'b0);
    checkFlag("reset_rdy0", o_req0_ready, 1'b0);
    checkFlag("reset_alloc", o_alloc, 1'b0);
    checkFlag("reset_rd", o_rd, 1'b0);
    checkFlag("reset_rsp0_valid", o_rsp0_valid, 1'b0);
    checkFlag("reset_rsp1_valid", o_rsp1_valid, 1'b0);
    checkOutput("reset_rsp0_data", o_rsp0_data, 16'h0);
    doReset();

    // Single alloc from requester 0.
    applyStimulus(1'b1, OpAlloc, 16'h0, 16'h1234, 1'b0, OpAlloc, 16'h0, 16'h0);
    @(negedge i_clk);
    checkFlag("alloc_rdy0", o_req0_ready, 1'b1);
    checkFlag("alloc_cmd", o_alloc, 1'b1);
    checkOutput("alloc_data", o_data, 16'h1234);
    step();
    idle();
    @(negedge i_clk);
    checkFlag("alloc_rsp0_valid", o_rsp0_valid, 1'b1);
    checkOutput("alloc_rsp0_data", o_rsp0_data, 16'h5000);
    checkFlag("alloc_rsp1_valid", o_rsp1_valid, 1'b0);

    // Contention table, starting from reset so requester 0 wins the first tie.
    vecs[0] = '{1'b1, OpRead, 16'h5000, 16'h0, 1'b1, OpWrite, 16'h5001, 16'h1111, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, OpRead, 16'h5000, 16'h0, 1'b1, OpWrite, 16'h5001, 16'h1111, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{1'b1, OpRead, 16'h5000, 16'h0, 1'b1, OpWrite, 16'h5001, 16'h1111, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{1'b1, OpRead, 16'h5000, 16'h0, 1'b1, OpWrite, 16'h5001, 16'h1111, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{1'b0, OpAlloc, 16'h0, 16'h0, 1'b0, OpAlloc, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{1'b0, OpAlloc, 16'h0, 16'h0, 1'b1, OpRead, 16'h5002, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{1'b1, OpWrite, 16'h5004, 16'h2222, 1'b0, OpAlloc, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{1'b0, OpAlloc, 16'h0, 16'h0, 1'b0, OpAlloc, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0};
    doReset();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].v0, vecs[i].op0, vecs[i].a0, vecs[i].d0,
                    vecs[i].v1, vecs[i].op1, vecs[i].a1, vecs[i].d1);
      @(negedge i_clk);
      checkFlag($sformatf("tbl%0d_rdy0", i), o_req0_ready, vecs[i].r0);
      checkFlag($sformatf("tbl%0d_rdy1", i), o_req1_ready, vecs[i].r1);
      checkFlag($sformatf("tbl%0d_rsp0_valid", i), o_rsp0_valid, vecs[i].rv0);
      checkFlag($sformatf("tbl%0d_rsp1_valid", i), o_rsp1_valid, vecs[i].rv1);
      checkFlag($sformatf("tbl%0d_rd_wr_excl", i), o_rd & o_wr, 1'b0);
      step();
    end

    // Write followed by read of the same cell from requester 1.
    applyStimulus(1'b0, OpAlloc, 16'h0, 16'h0, 1'b1, OpWrite, 16'h5001, 16'hBEEF);
    @(negedge i_clk);
    checkFlag("wr_rdy1", o_req1_ready, 1'b1);
    step();
    applyStimulus(1'b0, OpAlloc, 16'h0, 16'h0, 1'b1, OpRead, 16'h5001, 16'h0);
    @(negedge i_clk);
    checkFlag("rd_rdy1", o_req1_ready, 1'b1);
    checkFlag("wr_rsp1_valid", o_rsp1_valid, 1'b1);
    checkOutput("wr_rsp1_data", o_rsp1_data, 16'h0);
    step();
    idle();
    @(negedge i_clk);
    checkFlag("rd_rsp1_valid", o_rsp1_valid, 1'b1);
    checkOutput("rd_rsp1_data", o_rsp1_data, 16'hBEEF);
    step();

    // Alloc on requester 0 against free on requester 1 in the same cycle.
    doReset();
    applyStimulus(1'b1, OpAlloc, 16'h0, 16'hAAAA, 1'b1, OpFree, 16'h5003, 16'h0);
    @(negedge i_clk);
`ifdef ALLOC_ARB_PAIR_EN
    checkFlag("pair_rdy0", o_req0_ready, 1'b1);
    checkFlag("pair_rdy1", o_req1_ready, 1'b1);
    checkFlag("pair_alloc", o_alloc, 1'b1);
    checkFlag("pair_free", o_free, 1'b1);
    checkOutput("pair_data", o_data, 16'hAAAA);
    checkOutput("pair_faddr", o_faddr, 16'h5003);
    step();
    idle();
    @(negedge i_clk);
    checkFlag("pair_rsp0_valid", o_rsp0_valid, 1'b1);
    checkOutput("pair_rsp0_data", o_rsp0_data, 16'h5003);
    checkFlag("pair_rsp1_valid", o_rsp1_valid, 1'b1);
    checkOutput("pair_rsp1_data", o_rsp1_data, 16'h0);
`else
    checkFlag("nopair_rdy0", o_req0_ready, 1'b1);
    checkFlag("nopair_rdy1", o_req1_ready, 1'b0);
    checkFlag("nopair_alloc", o_alloc, 1'b1);
    checkFlag("nopair_free", o_free, 1'b0);
    step();
    applyStimulus(1'b0, OpAlloc, 16'h0, 16'h0, 1'b1, OpFree, 16'h5003, 16'h0);
    @(negedge i_clk);
    checkFlag("nopair_rdy1_2nd", o_req1_ready, 1'b1);
    checkFlag("nopair_free_2nd", o_free, 1'b1);
    checkFlag("nopair_rsp0_valid", o_rsp0_valid, 1'b1);
    checkOutput("nopair_rsp0_data", o_rsp0_data, 16'h5000);
    checkFlag("nopair_rsp1_early", o_rsp1_valid, 1'b0);
    step();
    idle();
    @(negedge i_clk);
    checkFlag("nopair_rsp1_valid", o_rsp1_valid, 1'b1);
    checkOutput("nopair_rsp1_data", o_rsp1_data, 16'h0);
    checkFlag("nopair_rsp0_after", o_rsp0_valid, 1'b0);
`endif
    step();

    // Reset in the cycle after an accepted read drops the pending response.
    doReset();
    applyStimulus(1'b1, OpRead, 16'h5000, 16'h0, 1'b0, OpAlloc, 16'h0, 16'h0);
    @(negedge i_clk);
    checkFlag("rstmid_rdy0", o_req0_ready, 1'b1);
    step();
    i_rst = 1'b1;
    idle();
    @(negedge i_clk);
    checkFlag("rstmid_rsp0_during", o_rsp0_valid, 1'b0);
    checkFlag("rstmid_rsp1_during", o_rsp1_valid, 1'b0);
    checkFlag("rstmid_halt", o_halt, 1'b0);
    step();
    step();
    i_rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge i_clk);
      checkFlag($sformatf("rstmid_rsp0_after%0d", i), o_rsp0_valid, 1'b0);
      checkFlag($sformatf("rstmid_halt_after%0d", i), o_halt, 1'b0);
      step();
    end

    // Exhaust all 256 cells; the next alloc provokes the error and the sticky halt.
    doReset();
    for (int k = 0; k < 256; k++) begin
      applyStimulus(1'b1, OpAlloc, 16'h0, 16'(k), 1'b0, OpAlloc, 16'h0, 16'h0);
      @(negedge i_clk);
      checkFlag($sformatf("exh_rdy0_%0d", k), o_req0_ready, 1'b1);
      step();
    end
    applyStimulus(1'b1, OpAlloc, 16'h0, 16'hDEAD, 1'b0, OpAlloc, 16'h0, 16'h0);
    @(negedge i_clk);
    checkFlag("exh_last_rdy0", o_req0_ready, 1'b1);
    step();
    @(negedge i_clk);
    checkFlag("err_rdy0", o_req0_ready, 1'b0);
    checkFlag("err_rsp0_valid", o_rsp0_valid, 1'b0);
    checkFlag("err_halt_not_yet", o_halt, 1'b0);
    step();
    applyStimulus(1'b1, OpAlloc, 16'h0, 16'h0, 1'b1, OpRead, 16'h5000, 16'h0);
    @(negedge i_clk);
    checkFlag("halt_set", o_halt, 1'b1);
    step();
    for (int i = 0; i < 10; i++) begin
      @(negedge i_clk);
      checkFlag($sformatf("halt_rdy0_%0d", i), o_req0_ready, 1'b0);
      checkFlag($sformatf("halt_rdy1_%0d", i), o_req1_ready, 1'b0);
      checkFlag($sformatf("halt_sticky_%0d", i), o_halt, 1'b1);
      step();
    end

    // Randomised traffic against a transaction-level reference model.
    doReset();
    rv0 = 1'b0; rv1 = 1'b0; sawRdy0 = 1'b0; sawRdy1 = 1'b0;
    rop0 = OpAlloc; rop1 = OpAlloc; ra0 = '0; ra1 = '0; rd0 = '0; rd1 = '0;
    lastWinner = 1;
    halted = 1'b0;
    expQ.delete();
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!rv0 || sawRdy0) newReq(rv0, rop0, ra0, rd0);
      if (!rv1 || sawRdy1) newReq(rv1, rop1, ra1, rd1);
      applyStimulus(rv0, rop0, ra0, rd0, rv1, rop1, ra1, rd1);
      @(negedge i_clk);
      pair = 1'b0;
`ifdef ALLOC_ARB_PAIR_EN
      pair = rv0 && rv1 && (((rop0 == OpAlloc) && (rop1 == OpFree)) ||
                            ((rop0 == OpFree) && (rop1 == OpAlloc)));
`endif
      if (halted || i_err) begin
        e0 = 1'b0; e1 = 1'b0;
      end else if (pair) begin
        e0 = 1'b1; e1 = 1'b1;
      end else if (rv0 && rv1) begin
        e0 = ((1 - lastWinner) == 0);
        e1 = !e0;
      end else begin
        e0 = rv0; e1 = rv1;
      end
      checkFlag("rnd_rdy0", o_req0_ready, e0);
      checkFlag("rnd_rdy1", o_req1_ready, e1);
      checkFlag("rnd_alloc", o_alloc, (e0 && rop0 == OpAlloc) || (e1 && rop1 == OpAlloc));
      checkFlag("rnd_free", o_free, (e0 && rop0 == OpFree) || (e1 && rop1 == OpFree));
      checkFlag("rnd_rd", o_rd, (e0 && rop0 == OpRead) || (e1 && rop1 == OpRead));
      checkFlag("rnd_wr", o_wr, (e0 && rop0 == OpWrite) || (e1 && rop1 == OpWrite));
      checkFlag("rnd_ptr_mem_excl", (o_alloc | o_free) & (o_rd | o_wr), 1'b0);
      x0 = 1'b0; x1 = 1'b0; xd0 = '0; xd1 = '0;
      while (expQ.size() > 0 && expQ[0].due == cyc) begin
        ent = expQ.pop_front();
        if (!i_err) begin
          if (ent.op == OpAlloc) dat = i_oaddr;
          else if (ent.op == OpRead) dat = i_rdata;
          else dat = '0;
          if (ent.id == 0) begin x0 = 1'b1; xd0 = dat; end
          else begin x1 = 1'b1; xd1 = dat; end
        end
      end
      checkFlag("rnd_rsp0_valid", o_rsp0_valid, x0);
      checkFlag("rnd_rsp1_valid", o_rsp1_valid, x1);
      if (x0) checkOutput("rnd_rsp0_data", o_rsp0_data, xd0);
      if (x1) checkOutput("rnd_rsp1_data", o_rsp1_data, xd1);
      if (e0) expQ.push_back('{cyc + 1, 0, rop0});
      if (e1) expQ.push_back('{cyc + 1, 1, rop1});
      if (e0 != e1) lastWinner = e0 ? 0 : 1;
      halted = halted | i_err;
      sawRdy0 = o_req0_ready;
      sawRdy1 = o_req1_ready;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
